button_debounce_fsm: RTL and testbench

Consumer side of the debounce tick generator. Samples a raw, asynchronous push-button input only on `sample_tick` strobes. It commits a new debounced level after `STABLE_TICKS` consecutive ticks that disagree with the current level. It outputs a clean level, one-cycle press/release pulses and a wrapping press counter for downstream control logic.

---
 rtl/button_debounce_fsm_pkg.sv | 13 +
 rtl/button_debounce_fsm_if.sv | 31 +++
 rtl/button_debounce_fsm_sync_2ff.sv | 28 ++
 rtl/button_debounce_fsm.sv | 140 ++++++++++++++
 tb/tb_button_debounce_fsm.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/button_debounce_fsm_pkg.sv
// Shared debounce definitions: FSM state encodings and default stability length.
package debounce_pkg;

  typedef enum logic [1:0] {
    REL    = 2'd0,
    WAIT_P = 2'd1,
    PRS    = 2'd2,
    WAIT_R = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_STABLE_TICKS = 4;

endpackage

// File: rtl/button_debounce_fsm_if.sv
// Button debounce bus: tick/raw inputs toward the FSM, debounced results back.
interface button_debounce_fsm_if #(
  parameter int unsigned CNT_W = 8
);

  logic             sample_tick;
  logic             btn_raw;
  logic             btn_level;
  logic             btn_press;
  logic             btn_release;
  logic [CNT_W-1:0] press_count;

  modport master (
    output sample_tick,
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  press_count
  );

  modport slave (
    input  sample_tick,
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output press_count
  );

endinterface

// File: rtl/button_debounce_fsm_sync_2ff.sv
// Two-flop synchronizer for asynchronous pin inputs; reset value is selectable
// so each pin can come out of reset at its idle level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_a,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Metastability filter: two back-to-back flops.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_debounce_fsm.sv
// Debounce FSM: samples the synchronized button on tick strobes and commits a
// new level after STABLE_TICKS consecutive disagreeing ticks.
module button_debounce_fsm
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DEFAULT_STABLE_TICKS,
  parameter bit          ACTIVE_LOW   = 1'b1,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                  clk,
  input  logic                  rst_a,
  button_debounce_fsm_if.slave  bus
);

  localparam logic             RAW_IDLE = ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [3:0]       LAST_CNT = 4'(STABLE_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic raw_sync;
  logic btn_s;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic [CNT_W-1:0] count_q, count_d;

  sync_2ff #(
    .RST_VAL (RAW_IDLE)
  ) u_sync (
    .clk   (clk),
    .rst_a (rst_a),
    .d     (bus.btn_raw),
    .q     (raw_sync)
  );

  assign btn_s = ACTIVE_LOW ? ~raw_sync : raw_sync;

  // State, tick counter and registered outputs.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_q   <= REL;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      count_q   <= count_d;
    end
  end

  // Next-state and commit decisions; everything holds on non-tick cycles.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    count_d   = count_q;
    if (bus.sample_tick) begin
      unique case (state_q)
        REL: begin
          if (btn_s) begin
            if (STABLE_TICKS == 1) begin
              state_d = PRS;
              cnt_d   = '0;
              level_d = 1'b1;
              press_d = 1'b1;
              count_d = count_q + CNT_ONE;
            end else begin
              state_d = WAIT_P;
              cnt_d   = 4'd1;
            end
          end
        end
        WAIT_P: begin
          if (btn_s) begin
            if (cnt_q == LAST_CNT) begin
              state_d = PRS;
              cnt_d   = '0;
              level_d = 1'b1;
              press_d = 1'b1;
              count_d = count_q + CNT_ONE;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            state_d = REL;
            cnt_d   = '0;
          end
        end
        PRS: begin
          if (!btn_s) begin
            if (STABLE_TICKS == 1) begin
              state_d   = REL;
              cnt_d     = '0;
              level_d   = 1'b0;
              release_d = 1'b1;
            end else begin
              state_d = WAIT_R;
              cnt_d   = 4'd1;
            end
          end
        end
        WAIT_R: begin
          if (!btn_s) begin
            if (cnt_q == LAST_CNT) begin
              state_d   = REL;
              cnt_d     = '0;
              level_d   = 1'b0;
              release_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            state_d = PRS;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = REL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.press_count = count_q;

endmodule

// File: tb/tb_button_debounce_fsm.sv
// Directed bench for button_debounce_fsm: STABLE_TICKS=4, active-low button,
// one tick every 10 clk. Expectations are queued as stimulus is applied and
// compared when the DUT result is due.
module tb_button_debounce_fsm;
  import debounce_pkg::*;

  logic clk   = 1'b0;
  logic rst_a = 1'b0;

  always #5 clk = ~clk;

  button_debounce_fsm_if #(.CNT_W(8)) bus ();

  button_debounce_fsm #(
    .STABLE_TICKS (4),
    .ACTIVE_LOW   (1'b1),
    .CNT_W        (8)
  ) dut (
    .clk   (clk),
    .rst_a (rst_a),
    .bus   (bus)
  );

  typedef struct {
    string tag;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   fails   = 0;

  int   tick_seen   = 0;
  int   press_seen  = 0;
  int   rel_seen    = 0;
  int   press_tick  = 0;
  int   width_err   = 0;
  int   overlap_err = 0;
  logic prev_p = 1'b0;
  logic prev_r = 1'b0;

  // Tick generator: one-cycle strobe every 10 clk, driven on the falling edge.
  initial begin
    bus.sample_tick = 1'b0;
    forever begin
      repeat (9) @(negedge clk);
      bus.sample_tick = 1'b1;
      @(negedge clk);
      bus.sample_tick = 1'b0;
    end
  end

  // Count ticks as the DUT consumes them.
  always @(posedge clk) begin
    if (bus.sample_tick) tick_seen <= tick_seen + 1;
  end

  // Pulse monitor: counts pulses, catches wide or overlapping pulses.
  always @(negedge clk) begin
    if (bus.btn_press) begin
      press_seen = press_seen + 1;
      press_tick = tick_seen;
    end
    if (bus.btn_release) rel_seen = rel_seen + 1;
    if (bus.btn_press && prev_p) width_err = width_err + 1;
    if (bus.btn_release && prev_r) width_err = width_err + 1;
    if (bus.btn_press && bus.btn_release) overlap_err = overlap_err + 1;
    prev_p = bus.btn_press;
    prev_r = bus.btn_release;
  end

  task automatic push(input string tag, input int exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check(input int obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL sb_empty: observed %0d with no expectation queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  // Returns 1 time unit after the falling edge that follows a consumed tick.
  task automatic wait_tick();
    int t0;
    t0 = tick_seen;
    for (int i = 0; i < 20 && tick_seen == t0; i++) @(negedge clk);
    if (tick_seen == t0) begin
      vectors++;
      fails++;
      $error("FAIL tick_timeout: observed no tick expected one within 20 clk");
    end
    #1;
  endtask

  task automatic do_reset(input logic raw);
    rst_a       = 1'b0;
    bus.btn_raw = raw;
    wait_tick();
    wait_tick();
    rst_a = 1'b1;
    wait_tick();
  endtask

  int t0, p0, r0;

  initial begin
    bus.btn_raw = 1'b0;   // pressed while reset is held
    rst_a       = 1'b0;

    // Reset with the button held down.
    wait_tick();
    wait_tick();
    push("rst_level", 0);
    push("rst_press", 0);
    push("rst_release", 0);
    push("rst_count", 0);
    push("rst_state", int'(REL));
    push("rst_no_pulse", 0);
    check(int'(bus.btn_level));
    check(int'(bus.btn_press));
    check(int'(bus.btn_release));
    check(int'(bus.press_count));
    check(int'(dut.state_q));
    check(press_seen + rel_seen);

    rst_a = 1'b1;
    t0    = tick_seen;
    push("rst_exit_3tick_level", 0);
    repeat (3) wait_tick();
    check(int'(bus.btn_level));
    push("rst_exit_4tick_level", 1);
    push("rst_exit_latency", 4);
    wait_tick();
    check(int'(bus.btn_level));
    check(press_tick - t0);

    // Clean press from a fresh released reset.
    do_reset(1'b1);
    p0 = press_seen;
    t0 = tick_seen;
    bus.btn_raw = 1'b0;
    push("clean_3tick_level", 0);
    push("clean_level", 1);
    push("clean_latency", 4);
    push("clean_press_pulses", 1);
    push("clean_count", 1);
    repeat (3) wait_tick();
    check(int'(bus.btn_level));
    wait_tick();
    check(int'(bus.btn_level));
    check(press_tick - t0);
    check(press_seen - p0);
    check(int'(bus.press_count));

    // Release.
    p0 = press_seen;
    r0 = rel_seen;
    bus.btn_raw = 1'b1;
    push("rel_level", 0);
    push("rel_pulses", 1);
    push("rel_press_pulses", 0);
    push("rel_count", 1);
    repeat (4) wait_tick();
    check(int'(bus.btn_level));
    check(rel_seen - r0);
    check(press_seen - p0);
    check(int'(bus.press_count));

    // Bouncy press: toggle every 3 clk for ~40 clk, then hold pressed.
    p0 = press_seen;
    r0 = rel_seen;
    push("bounce_press_pulses", 1);
    push("bounce_rel_pulses", 0);
    push("bounce_count", 2);
    push("bounce_level", 1);
    for (int i = 0; i < 13; i++) begin
      repeat (3) @(negedge clk);
      bus.btn_raw = ~bus.btn_raw;
    end
    bus.btn_raw = 1'b0;
    repeat (6) wait_tick();
    check(press_seen - p0);
    check(rel_seen - r0);
    check(int'(bus.press_count));
    check(int'(bus.btn_level));

    // Glitch rejection: 3 pressed ticks then release.
    bus.btn_raw = 1'b1;
    repeat (6) wait_tick();
    p0 = press_seen;
    r0 = rel_seen;
    bus.btn_raw = 1'b0;
    push("glitch_wait_state", int'(WAIT_P));
    push("glitch_state", int'(REL));
    push("glitch_level", 0);
    push("glitch_pulses", 0);
    repeat (3) wait_tick();
    check(int'(dut.state_q));
    bus.btn_raw = 1'b1;
    repeat (2) wait_tick();
    check(int'(dut.state_q));
    check(int'(bus.btn_level));
    check((press_seen - p0) + (rel_seen - r0));

    // Reset while in WAIT_P with cnt=2.
    bus.btn_raw = 1'b0;
    push("midwait_state", int'(WAIT_P));
    push("midwait_cnt", 2);
    repeat (2) wait_tick();
    check(int'(dut.state_q));
    check(int'(dut.cnt_q));
    p0 = press_seen;
    r0 = rel_seen;
    push("midrst_state", int'(REL));
    push("midrst_cnt", 0);
    push("midrst_level", 0);
    push("midrst_count", 0);
    push("midrst_pulses", 0);
    rst_a = 1'b0;
    #1;
    check(int'(dut.state_q));
    check(int'(dut.cnt_q));
    check(int'(bus.btn_level));
    check(int'(bus.press_count));
    bus.btn_raw = 1'b1;
    wait_tick();
    wait_tick();
    check((press_seen - p0) + (rel_seen - r0));
    rst_a = 1'b1;
    wait_tick();

    // Counter wrap over 256 clean presses.
    p0 = press_seen;
    push("wrap_255", 255);
    push("wrap_0", 0);
    push("wrap_presses", 256);
    for (int i = 0; i < 256; i++) begin
      bus.btn_raw = 1'b0;
      repeat (4) wait_tick();
      if (i == 254) check(int'(bus.press_count));
      bus.btn_raw = 1'b1;
      repeat (4) wait_tick();
    end
    check(int'(bus.press_count));
    check(press_seen - p0);

    // Pulse shape over the whole run.
    push("pulse_width", 0);
    push("pulse_overlap", 0);
    check(width_err);
    check(overlap_err);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
